shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl.sv | 141 ++++++++++++++
 tb/tb_shift_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ctrl.sv
// rtl/shift_ctrl.sv - line-window controller for an 11-tap pixel shift register
module shift_ctrl #(
    parameter int LINE_W = 640,
    parameter int TAPS   = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pix_valid,
    input  logic       line_start,
    output logic       shift_en,
    output logic       pad_en,
    output logic       win_valid,
    output logic [9:0] col,
    output logic       edge_l,
    output logic       edge_r,
    output logic       busy,
    output logic       err
);

    localparam int HALF = TAPS / 2;

    // center tap first holds pixel 0 once HALF+1 pixels have been shifted in
    localparam logic [9:0] FIRST_WIN  = 10'(HALF + 1);
    localparam logic [9:0] LINE_LAST  = 10'(LINE_W);
    localparam logic [9:0] FLUSH_BASE = 10'(LINE_W - HALF);
    localparam logic [9:0] RIGHT_LIM  = 10'(LINE_W - HALF - 1);
    localparam logic [9:0] LEFT_LIM   = 10'(HALF);
    localparam logic [2:0] FL_LAST    = 3'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [9:0] in_cnt, in_cnt_nx;
    logic [2:0] fl_cnt, fl_cnt_nx;
    logic [9:0] col_nx;
    logic       win_nx;
    logic       err_nx;
    logic [9:0] in_inc;

    assign in_inc = in_cnt + 10'd1;

    // next-state, counter updates and the combinational shift/pad strobes
    always_comb begin
        state_nx  = state;
        in_cnt_nx = in_cnt;
        fl_cnt_nx = fl_cnt;
        col_nx    = col;
        win_nx    = 1'b0;
        err_nx    = 1'b0;
        shift_en  = 1'b0;
        pad_en    = 1'b0;
        if (rst_n && enable) begin
            if (line_start && state != IDLE) begin
                // abort the current line; a coincident pixel starts the next one
                err_nx    = 1'b1;
                col_nx    = 10'd0;
                fl_cnt_nx = 3'd0;
                shift_en  = pix_valid;
                if (pix_valid) begin
                    state_nx  = FILL;
                    in_cnt_nx = 10'd1;
                end else begin
                    state_nx  = IDLE;
                    in_cnt_nx = 10'd0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (line_start && pix_valid) begin
                            shift_en  = 1'b1;
                            state_nx  = FILL;
                            in_cnt_nx = 10'd1;
                        end
                    end
                    FILL, RUN: begin
                        if (pix_valid) begin
                            shift_en  = 1'b1;
                            in_cnt_nx = in_inc;
                            if (in_inc >= FIRST_WIN) begin
                                win_nx = 1'b1;
                                col_nx = in_inc - FIRST_WIN;
                            end
                            if (state == FILL && in_inc == FIRST_WIN)
                                state_nx = RUN;
                            if (state == RUN && in_inc == LINE_LAST)
                                state_nx = FLUSH;
                        end
                    end
                    FLUSH: begin
                        // camera pixels are ignored here; zeros are pushed instead
                        shift_en = 1'b1;
                        pad_en   = 1'b1;
                        err_nx   = pix_valid;
                        win_nx   = 1'b1;
                        col_nx   = FLUSH_BASE + {7'd0, fl_cnt};
                        if (fl_cnt == FL_LAST) begin
                            state_nx  = IDLE;
                            in_cnt_nx = 10'd0;
                            fl_cnt_nx = 3'd0;
                        end else begin
                            fl_cnt_nx = fl_cnt + 3'd1;
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    // state, counters and registered window outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_cnt    <= 10'd0;
            fl_cnt    <= 3'd0;
            col       <= 10'd0;
            win_valid <= 1'b0;
            edge_l    <= 1'b0;
            edge_r    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            in_cnt    <= in_cnt_nx;
            fl_cnt    <= fl_cnt_nx;
            col       <= col_nx;
            win_valid <= win_nx;
            edge_l    <= win_nx && (col_nx < LEFT_LIM);
            edge_r    <= win_nx && (col_nx > RIGHT_LIM);
            busy      <= (state_nx != IDLE);
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// tb/tb_shift_ctrl.sv - scoreboard bench for shift_ctrl
module tb_shift_ctrl;

    logic clk = 1'b0;
    logic rst_n, enable;
    logic pv_l, ls_l, pv_s, ls_s;
    logic shift_en_l, pad_en_l, win_valid_l, edge_l_l, edge_r_l, busy_l, err_l;
    logic shift_en_s, pad_en_s, win_valid_s, edge_l_s, edge_r_s, busy_s, err_s;
    logic [9:0] col_l, col_s;

    always #5 clk = ~clk;

    shift_ctrl #(.LINE_W(640), .TAPS(11)) u_l (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pv_l), .line_start(ls_l),
        .shift_en(shift_en_l), .pad_en(pad_en_l), .win_valid(win_valid_l), .col(col_l),
        .edge_l(edge_l_l), .edge_r(edge_r_l), .busy(busy_l), .err(err_l)
    );

    shift_ctrl #(.LINE_W(12), .TAPS(11)) u_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pv_s), .line_start(ls_s),
        .shift_en(shift_en_s), .pad_en(pad_en_s), .win_valid(win_valid_s), .col(col_s),
        .edge_l(edge_l_s), .edge_r(edge_r_s), .busy(busy_s), .err(err_s)
    );

    typedef struct {
        int c;
        bit el;
        bit er;
    } exp_t;

    exp_t ql[$];
    exp_t qs[$];

    int n_chk = 0;
    int n_err = 0;
    int sh_l = 0, pd_l = 0, er_l = 0;
    int sh_s = 0, pd_s = 0, er_s = 0, pad_early = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // expected window for a line of width lw: center column plus border flags
    task automatic push_l(input int from, input int to);
        for (int c = from; c <= to; c++) ql.push_back('{c, c < 5, c > 640 - 6});
    endtask

    task automatic push_s(input int from, input int to);
        for (int c = from; c <= to; c++) qs.push_back('{c, c < 5, c > 12 - 6});
    endtask

    task automatic step(input bit en, input bit pl, input bit ll, input bit ps, input bit lss);
        enable = en; pv_l = pl; ls_l = ll; pv_s = ps; ls_s = lss;
        @(posedge clk);
        #1;
    endtask

    task automatic stl(input bit pl, input bit ll);
        step(1'b1, pl, ll, 1'b0, 1'b0);
    endtask

    task automatic feed_l(input int n);
        for (int i = 0; i < n; i++) stl(1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) stl(1'b0, 1'b0);
    endtask

    // monitor for the 640-wide instance
    always @(negedge clk) begin
        exp_t e;
        if (shift_en_l) sh_l++;
        if (pad_en_l) pd_l++;
        if (err_l) er_l++;
        if (win_valid_l) begin
            if (ql.size() == 0) begin
                chk("unexpected_win_l", {22'd0, col_l}, 32'hFFFF);
            end else begin
                e = ql.pop_front();
                chk("col_l", {22'd0, col_l}, e.c);
                chk("edge_l_l", {31'd0, edge_l_l}, {31'd0, e.el});
                chk("edge_r_l", {31'd0, edge_r_l}, {31'd0, e.er});
            end
        end
    end

    // monitor for the 12-wide instance
    always @(negedge clk) begin
        exp_t e;
        if (pad_en_s && sh_s < 12) pad_early++;
        if (shift_en_s) sh_s++;
        if (pad_en_s) pd_s++;
        if (err_s) er_s++;
        if (win_valid_s) begin
            if (qs.size() == 0) begin
                chk("unexpected_win_s", {22'd0, col_s}, 32'hFFFF);
            end else begin
                e = qs.pop_front();
                chk("col_s", {22'd0, col_s}, e.c);
                chk("edge_l_s", {31'd0, edge_l_s}, {31'd0, e.el});
                chk("edge_r_s", {31'd0, edge_r_s}, {31'd0, e.er});
            end
        end
    end

    initial begin
        int base, e0, s0;
        rst_n = 1'b0;
        enable = 1'b1; pv_l = 1'b0; ls_l = 1'b0; pv_s = 1'b0; ls_s = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_win", {31'd0, win_valid_l}, 0);
        chk("rst_busy", {31'd0, busy_l}, 0);
        chk("rst_col", {22'd0, col_l}, 0);
        chk("rst_err", {31'd0, err_l}, 0);
        chk("rst_busy_s", {31'd0, busy_s}, 0);
        rst_n = 1'b1;
        idle(2);

        // 12-pixel line, continuous pixels
        push_s(0, 11);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("s_busy_mid", {31'd0, busy_s}, 1);
        idle(8);
        chk("s_shifts", sh_s, 17);
        chk("s_pads", pd_s, 5);
        chk("s_pad_early", pad_early, 0);
        chk("s_q_left", qs.size(), 0);
        chk("s_busy_end", {31'd0, busy_s}, 0);
        chk("s_err", er_s, 0);

        // 640-pixel line with alternating pix_valid
        base = sh_l;
        push_l(0, 639);
        stl(1'b1, 1'b1);
        for (int i = 0; i < 639; i++) begin
            stl(1'b0, 1'b0);
            stl(1'b1, 1'b0);
        end
        idle(8);
        chk("a_shifts", sh_l - base, 645);
        chk("a_err", er_l, 0);
        chk("a_q_left", ql.size(), 0);
        chk("a_busy_end", {31'd0, busy_l}, 0);

        // restart at in_cnt = 100
        push_l(0, 94);
        stl(1'b1, 1'b1);
        feed_l(99);
        e0 = er_l;
        push_l(0, 639);
        stl(1'b1, 1'b1);
        feed_l(639);
        idle(8);
        chk("b_err", er_l - e0, 1);
        chk("b_q_left", ql.size(), 0);

        // freeze in RUN and in FLUSH
        push_l(0, 639);
        stl(1'b1, 1'b1);
        feed_l(299);
        s0 = sh_l;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("c_freeze_run_shifts", sh_l - s0, 0);
        chk("c_freeze_run_col", {22'd0, col_l}, 294);
        chk("c_freeze_run_busy", {31'd0, busy_l}, 1);
        feed_l(340);
        idle(2);
        s0 = sh_l;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("c_freeze_fl_shifts", sh_l - s0, 0);
        chk("c_freeze_fl_col", {22'd0, col_l}, 636);
        idle(8);
        chk("c_q_left", ql.size(), 0);
        chk("c_busy_end", {31'd0, busy_l}, 0);

        // reset at in_cnt = 300
        push_l(0, 294);
        stl(1'b1, 1'b1);
        feed_l(299);
        e0 = er_l;
        rst_n = 1'b0; pv_l = 1'b1;
        #3;
        chk("d_rst_shift_en", {31'd0, shift_en_l}, 0);
        chk("d_rst_pad_en", {31'd0, pad_en_l}, 0);
        @(posedge clk);
        #1;
        chk("d_rst_win", {31'd0, win_valid_l}, 0);
        chk("d_rst_busy", {31'd0, busy_l}, 0);
        chk("d_rst_col", {22'd0, col_l}, 0);
        chk("d_rst_edge_l", {31'd0, edge_l_l}, 0);
        chk("d_rst_edge_r", {31'd0, edge_r_l}, 0);
        chk("d_rst_err", {31'd0, err_l}, 0);
        rst_n = 1'b1;
        chk("d_q_after_rst", ql.size(), 0);
        idle(1);
        push_l(0, 639);
        stl(1'b1, 1'b1);
        feed_l(639);
        idle(8);
        chk("d_err", er_l - e0, 0);
        chk("d_q_left", ql.size(), 0);

        // pix_valid during FLUSH
        push_l(0, 639);
        base = sh_l;
        e0 = er_l;
        stl(1'b1, 1'b1);
        feed_l(639);
        stl(1'b0, 1'b0);
        stl(1'b1, 1'b0);
        idle(6);
        chk("e_shifts", sh_l - base, 645);
        chk("e_err", er_l - e0, 1);
        chk("e_q_left", ql.size(), 0);
        chk("e_busy_end", {31'd0, busy_l}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
